btn_event: RTL
==============

# btn_event

Multi-button front end that synchronises raw push-button inputs, debounces them on a slow sample tick, and turns them into single-cycle event pulses: press, release and long-press. It also outputs a clean level for each button. It sits directly upstream of the LED pattern logic and drives that logic's button-event input; `BTNOUT` is a drop-in one-cycle press pulse. Each button runs an independent debounce FSM; one prescaler is shared by all buttons.

## Interface
Parameters:
- `NBTN`, 1: number of buttons, 1–8.
- `SAMPLE_DIV`, 500000: CLK cycles per sample tick (10 ms at 50 MHz). Must be ≥ 2.
- `STABLE_CNT`, 3: consecutive equal samples required to accept a level change. Must be ≥ 2.
- `LONG_TICKS`, 100: held ticks, counted from the press event, before the long-press pulse fires. Must be ≥ 1.

Ports:
- `CLK`  in  1  system clock; single clock domain.
- `RST`  in  1  synchronous, active-high reset.
- `BTNIN`  in  NBTN  raw asynchronous button inputs; 1 = pressed.
- `BTNOUT`  out  NBTN  one-CLK press pulse per button.
- `BTNREL`  out  NBTN  one-CLK release pulse per button.
- `BTNLONG`  out  NBTN  one-CLK long-press pulse per button.
- `BTNLVL`  out  NBTN  debounced level per button.

## Operation
- Synchroniser: 2-flop synchroniser per bit (`s1`, `s2`), both reset to 0. The FSM samples `s2` only.
- Prescaler:
  - `pcnt` has width clog2(`SAMPLE_DIV`) and counts 0 to `SAMPLE_DIV`-1, then wraps to 0.
  - `tick` = (`pcnt` == `SAMPLE_DIV`-1), combinational, high for one cycle every `SAMPLE_DIV` cycles.
- Per-button state: FSM plus `scnt` (width clog2(`STABLE_CNT`)) and `hcnt` (width clog2(`LONG_TICKS`+1), saturating). State changes only in cycles where `tick`=1.
- IDLE (level 0):
  - `s2`=1 → PDEB, `scnt`←1.
- PDEB:
  - `s2`=0 → IDLE, `scnt`←0.
  - `s2`=1 and `scnt`==`STABLE_CNT`-1 → HELD, pulse `BTNOUT`, `scnt`←0, `hcnt`←0.
  - Otherwise `scnt`++.
- HELD (level 1):
  - `s2`=0 → RDEB, `scnt`←1.
  - `s2`=1 and `hcnt`<`LONG_TICKS` → `hcnt`++. If the old `hcnt`==`LONG_TICKS`-1, pulse `BTNLONG`.
  - At `LONG_TICKS`, `hcnt` saturates, so `BTNLONG` fires at most once per press.
- RDEB (level 1):
  - `s2`=1 → HELD, `scnt`←0, `hcnt` retained with no increment. The bounce is absorbed and produces no event.
  - `s2`=0 and `scnt`==`STABLE_CNT`-1 → IDLE, pulse `BTNREL`, `hcnt`←0.
  - Otherwise `scnt`++.
- Outputs:
  - `BTNLVL` = 1 in HELD or RDEB; registered.
  - All pulses are registered and high for exactly one CLK cycle, in the cycle right after the tick edge that makes the transition. They coincide with the new state.
- Simultaneous events:
  - Buttons are fully independent; several bits may pulse in the same cycle.
  - `BTNOUT` and `BTNREL` can never be high together on the same bit.
  - `BTNLONG` and `BTNREL` can never be high together on the same bit.
- Reset (`RST`=1 at any CLK edge, including mid-debounce or while held):
  - `pcnt`, `s1`, `s2`, `scnt` and `hcnt` ← 0.
  - All FSMs ← IDLE.
  - All outputs ← 0 on the next cycle.
  - No release pulse is generated for a button that was held when reset hit.
  - After reset the first `tick` occurs `SAMPLE_DIV` cycles after the first edge with `RST`=0.

## Timing
- Reset values: `BTNOUT`, `BTNREL`, `BTNLONG` and `BTNLVL` are all 0.
- Input to `s2` latency: 2 CLK cycles.
- Clean press, `BTNIN` rising to `BTNOUT`: between 2+(`STABLE_CNT`-1)·`SAMPLE_DIV`+1 and 2+`STABLE_CNT`·`SAMPLE_DIV` cycles, depending on tick phase.
- `BTNLONG` follows `BTNOUT` by exactly `LONG_TICKS`·`SAMPLE_DIV` cycles if the button is held without a release.
- A glitch shorter than (`STABLE_CNT`-1)·`SAMPLE_DIV` cycles never produces an event.
- No handshake: consumers must capture pulses in the cycle they appear.

## Test plan
Bench parameters: `SAMPLE_DIV`=4, `STABLE_CNT`=3, `LONG_TICKS`=5, `NBTN`=2.

- Reset: hold `RST`=1 with `BTNIN`=2'b11 → all outputs stay 0 throughout. Release `RST`, keep `BTNIN`=11 → first tick 4 cycles later; `BTNOUT`=11 one-cycle pulse after the 3rd tick; `BTNLVL`=11.
- Clean press and release on bit 0 → exactly one `BTNOUT[0]`, then exactly one `BTNREL[0]`. Check:
  - Press-to-pulse latency within 11..14 cycles.
  - `BTNLVL[0]` high from the press pulse until the release pulse.
- Bounce: `BTNIN[0]` toggles every 3 cycles for 40 cycles, then stays 1 → exactly one `BTNOUT[0]`, no `BTNREL[0]`. A single 0-sample dip while held → no `BTNREL` and no second `BTNOUT`.
- Long press: hold bit 1 for 40 ticks → `BTNLONG[1]` exactly once, 20 cycles after `BTNOUT[1]`; release then gives `BTNREL[1]` and no further long pulse.
- Reset mid-hold: assert `RST` for 1 cycle while bit 0 is in HELD → `BTNLVL[0]`=0 next cycle, no `BTNREL[0]`; a new press after reset is detected normally.
- Concurrent: both buttons pressed on the same cycle → `BTNOUT`=2'b11 in a single cycle. Bit 0 released while bit 1 is still held → `BTNREL`=2'b01 only.

Source files
------------

// File: rtl/btn_event.sv
// btn_event: synchronise, debounce and edge-detect NBTN push buttons.
// Ports: CLK, RST (sync, active high), BTNIN raw inputs,
//   BTNOUT/BTNREL/BTNLONG one-cycle press/release/long pulses,
//   BTNLVL debounced level. One sample prescaler shared by all buttons.
module btn_event #(
    parameter int NBTN       = 1,
    parameter int SAMPLE_DIV = 500000,
    parameter int STABLE_CNT = 3,
    parameter int LONG_TICKS = 100
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NBTN-1:0] BTNIN,
    output logic [NBTN-1:0] BTNOUT,
    output logic [NBTN-1:0] BTNREL,
    output logic [NBTN-1:0] BTNLONG,
    output logic [NBTN-1:0] BTNLVL
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int SW = $clog2(STABLE_CNT);
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] PLAST = PW'(SAMPLE_DIV - 1);
    localparam logic [SW-1:0] SLAST = SW'(STABLE_CNT - 1);
    localparam logic [HW-1:0] HSAT  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HPRE  = HW'(LONG_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PDEB,
        HELD,
        RDEB
    } state_e;

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [NBTN-1:0] s1_q, s1_d;
    logic [NBTN-1:0] s2_q, s2_d;
    logic            tick;

    state_e          state_q [NBTN];
    state_e          state_d [NBTN];
    logic [SW-1:0]   scnt_q  [NBTN];
    logic [SW-1:0]   scnt_d  [NBTN];
    logic [HW-1:0]   hcnt_q  [NBTN];
    logic [HW-1:0]   hcnt_d  [NBTN];

    logic [NBTN-1:0] out_q, out_d;
    logic [NBTN-1:0] rel_q, rel_d;
    logic [NBTN-1:0] long_q, long_d;
    logic [NBTN-1:0] lvl_q, lvl_d;

    assign tick = (pcnt_q == PLAST);

    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        s1_d   = BTNIN;
        s2_d   = s1_q;
        out_d  = '0;
        rel_d  = '0;
        long_d = '0;
        lvl_d  = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            scnt_d[i]  = scnt_q[i];
            hcnt_d[i]  = hcnt_q[i];
            if (tick) begin
                unique case (state_q[i])
                    IDLE: begin
                        if (s2_q[i]) begin
                            state_d[i] = PDEB;
                            scnt_d[i]  = SW'(1);
                        end
                    end
                    PDEB: begin
                        if (!s2_q[i]) begin
                            state_d[i] = IDLE;
                            scnt_d[i]  = '0;
                        end else if (scnt_q[i] == SLAST) begin
                            state_d[i] = HELD;
                            scnt_d[i]  = '0;
                            hcnt_d[i]  = '0;
                            out_d[i]   = 1'b1;
                        end else begin
                            scnt_d[i] = scnt_q[i] + SW'(1);
                        end
                    end
                    HELD: begin
                        if (!s2_q[i]) begin
                            state_d[i] = RDEB;
                            scnt_d[i]  = SW'(1);
                        end else if (hcnt_q[i] < HSAT) begin
                            // saturation keeps the long pulse to one per press
                            hcnt_d[i] = hcnt_q[i] + HW'(1);
                            long_d[i] = (hcnt_q[i] == HPRE);
                        end
                    end
                    RDEB: begin
                        if (s2_q[i]) begin
                            // bounce while held: resume without touching hcnt
                            state_d[i] = HELD;
                            scnt_d[i]  = '0;
                        end else if (scnt_q[i] == SLAST) begin
                            state_d[i] = IDLE;
                            scnt_d[i]  = '0;
                            hcnt_d[i]  = '0;
                            rel_d[i]   = 1'b1;
                        end else begin
                            scnt_d[i] = scnt_q[i] + SW'(1);
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
            lvl_d[i] = (state_d[i] == HELD) || (state_d[i] == RDEB);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pcnt_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rel_q  <= '0;
            long_q <= '0;
            lvl_q  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= IDLE;
                scnt_q[i]  <= '0;
                hcnt_q[i]  <= '0;
            end
        end else begin
            pcnt_q <= pcnt_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            out_q  <= out_d;
            rel_q  <= rel_d;
            long_q <= long_d;
            lvl_q  <= lvl_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                scnt_q[i]  <= scnt_d[i];
                hcnt_q[i]  <= hcnt_d[i];
            end
        end
    end

    assign BTNOUT  = out_q;
    assign BTNREL  = rel_q;
    assign BTNLONG = long_q;
    assign BTNLVL  = lvl_q;

endmodule
